// File: rtl/cont_ip_axil_slave.sv
// cont_ip AXI4-Lite slave: config registers plus a prescaled compare/reload counter.
// Optional irq output when CONT_IP_IRQ_EN is defined.
module cont_ip_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cnt_value,
    output logic                              cnt_match
`ifdef CONT_IP_IRQ_EN
    ,
    output logic                              irq
`endif
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic          r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic          r_aw_full, r_w_full;
    logic [2:0]    r_awidx;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_wstrb;
    logic [1:0]    r_bresp, r_rresp;
    logic [DW-1:0] r_rdata;

    logic [DW-1:0] r_ctrl, r_load, r_cmp, r_presc, r_count, r_pre;
    logic          r_match, r_running, r_cnt_match;

    logic          w_commit, w_wr_err;
    logic          w_wr_ctrl, w_wr_load, w_wr_cmp, w_wr_presc, w_wr_count, w_wr_stat;
    logic          w_active, w_tick, w_hit;
    logic [DW-1:0] w_ctrl_new;
    logic [DW-1:0] w_rd_data;
    logic          w_rd_err;
    logic          w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old,
                                              input logic [DW-1:0] d,
                                              input logic [3:0]    s);
        logic [DW-1:0] v;
        v = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
        return v;
    endfunction

    assign w_commit   = r_aw_full & r_w_full & ~r_bvalid;
    assign w_wr_err   = (r_awidx[2:1] == 2'b11);
    assign w_wr_ctrl  = w_commit & (r_awidx == 3'd0);
    assign w_wr_load  = w_commit & (r_awidx == 3'd1);
    assign w_wr_cmp   = w_commit & (r_awidx == 3'd2);
    assign w_wr_presc = w_commit & (r_awidx == 3'd3);
    assign w_wr_count = w_commit & (r_awidx == 3'd4);
    assign w_wr_stat  = w_commit & (r_awidx == 3'd5);
    assign w_ctrl_new = f_merge(r_ctrl, r_wdata, r_wstrb);

    // A bus write to COUNT pre-empts match evaluation on the same tick
    assign w_active = r_ctrl[0] & r_running;
    assign w_tick   = w_active & (r_pre == r_presc);
    assign w_hit    = w_tick & ~w_wr_count & (r_count == r_cmp);

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (S_AXI_ARADDR[4:2])
            3'd0:    w_rd_data = r_ctrl;
            3'd1:    w_rd_data = r_load;
            3'd2:    w_rd_data = r_cmp;
            3'd3:    w_rd_data = r_presc;
            3'd4:    w_rd_data = r_count;
            3'd5:    w_rd_data = {{(DW-2){1'b0}}, r_running, r_match};
            default: w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= '0;
            r_rresp   <= '0;
            r_rdata   <= '0;
        end else begin
            if (S_AXI_AWVALID && r_awready) begin
                r_aw_full <= 1'b1;
                r_awready <= 1'b0;
                r_awidx   <= S_AXI_AWADDR[4:2];
            end else if (!r_aw_full) begin
                r_awready <= 1'b1;
            end
            if (S_AXI_WVALID && r_wready) begin
                r_w_full <= 1'b1;
                r_wready <= 1'b0;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end else if (!r_w_full) begin
                r_wready <= 1'b1;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
            end
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid  <= 1'b0;
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
            if (S_AXI_ARVALID && r_arready) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_data;
                r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end else if (!r_rvalid) begin
                r_arready <= 1'b1;
            end
        end
    end

    // Later assignments win: bus writes override the counter, match set beats W1C
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_ctrl      <= '0;
            r_load      <= '0;
            r_cmp       <= '0;
            r_presc     <= '0;
            r_count     <= '0;
            r_pre       <= '0;
            r_match     <= 1'b0;
            r_running   <= 1'b0;
            r_cnt_match <= 1'b0;
        end else begin
            r_cnt_match <= 1'b0;
            if (w_active)
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                if (w_hit) begin
                    r_count     <= r_load;
                    r_cnt_match <= 1'b1;
                    if (r_ctrl[1])
                        r_running <= 1'b0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_wr_stat && r_wstrb[0] && r_wdata[0])
                r_match <= 1'b0;
            if (w_hit)
                r_match <= 1'b1;
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_new;
                if (w_ctrl_new[0])
                    r_running <= 1'b1;
            end
            if (w_wr_load)
                r_load <= f_merge(r_load, r_wdata, r_wstrb);
            if (w_wr_cmp)
                r_cmp <= f_merge(r_cmp, r_wdata, r_wstrb);
            if (w_wr_presc)
                r_presc <= f_merge(r_presc, r_wdata, r_wstrb);
            if (w_wr_count) begin
                r_count <= f_merge(r_count, r_wdata, r_wstrb);
                r_pre   <= '0;
            end
        end
    end

`ifdef CONT_IP_IRQ_EN
    logic r_irq;
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_irq <= 1'b0;
        else
            r_irq <= r_match & r_ctrl[2];
    end
    assign irq = r_irq;
`endif

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign cnt_value     = r_count;
    assign cnt_match     = r_cnt_match;
endmodule

// File: tb/tb_cont_ip_axil_slave.sv
// Scoreboard bench for cont_ip_axil_slave: random register traffic plus
// directed counter, error, strobe, back-pressure and reset scenarios.
module tb_cont_ip_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] cnt_value;
    logic        cnt_match;
`ifdef CONT_IP_IRQ_EN
    logic        irq;
`endif

    always #5 ACLK = ~ACLK;

    cont_ip_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .cnt_value(cnt_value), .cnt_match(cnt_match)
`ifdef CONT_IP_IRQ_EN
        , .irq(irq)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  q_b[$];
    rexp_t       q_r[$];
    logic [31:0] m_reg[5];
    logic        m_match;
    logic        m_run;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = '0;
        m_match = 1'b0;
        m_run   = 1'b0;
    endtask

    function automatic logic [1:0] model_write(input logic [4:0] a,
                                               input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        idx = int'(a[4:2]);
        if (idx >= 6) return 2'b10;
        if (idx == 5) begin
            if (s[0] && d[0]) m_match = 1'b0;
            return 2'b00;
        end
        for (int b = 0; b < 4; b++)
            if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
        if (idx == 0 && m_reg[0][0]) m_run = 1'b1;
        return 2'b00;
    endfunction

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(a[4:2]);
        d = '0;
        r = 2'b00;
        if (idx >= 6) r = 2'b10;
        else if (idx == 5) d = {30'b0, m_run, m_match};
        else d = m_reg[idx];
    endtask

    function automatic logic rdy(input int ch);
        case (ch)
            0: return S_AXI_AWREADY;
            1: return S_AXI_WREADY;
            2: return S_AXI_BVALID;
            3: return S_AXI_ARREADY;
            default: return S_AXI_RVALID;
        endcase
    endfunction

    task automatic wait_hs(input int ch);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs) begin
            @(negedge ACLK);
            hs = rdy(ch);
            @(posedge ACLK);
            #1;
            n++;
            if (!hs && n > 200) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout channel=%0d actual=none required=handshake", ch);
                hs = 1'b1;
            end
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int wgap, input int bhold, input bit hold_chk);
        q_b.push_back(model_write(a, d, s));
        fork
            begin
                S_AXI_AWADDR  = a;
                S_AXI_AWVALID = 1'b1;
                wait_hs(0);
                S_AXI_AWVALID = 1'b0;
            end
            begin
                repeat (wgap) begin @(posedge ACLK); #1; end
                S_AXI_WDATA  = d;
                S_AXI_WSTRB  = s;
                S_AXI_WVALID = 1'b1;
                wait_hs(1);
                S_AXI_WVALID = 1'b0;
            end
        join
        for (int i = 0; i < bhold; i++) begin
            @(negedge ACLK);
            if (hold_chk && i >= 1) begin
                chk("b_hold_bvalid", S_AXI_BVALID, 1);
                chk("b_hold_awready", S_AXI_AWREADY, 0);
            end
            @(posedge ACLK);
            #1;
        end
        S_AXI_BREADY = 1'b1;
        wait_hs(2);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er,
                            input int rhold);
        rexp_t e;
        e.data = ed;
        e.resp = er;
        q_r.push_back(e);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        wait_hs(3);
        S_AXI_ARVALID = 1'b0;
        repeat (rhold) begin @(posedge ACLK); #1; end
        S_AXI_RREADY = 1'b1;
        wait_hs(4);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic mread(input logic [4:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        model_read(a, d, r);
        axi_read(a, d, r, 0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        axi_write(a, d, 4'hF, 0, 0, 0);
    endtask

    // Scoreboard monitor: pops an expectation whenever a response completes
    always @(negedge ACLK) begin
        if (ARESETN === 1'b1) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected actual=bresp_%b required=none", S_AXI_BRESP);
                end else begin
                    chk("bresp", S_AXI_BRESP, q_b.pop_front());
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (q_r.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected actual=rdata_%h required=none", S_AXI_RDATA);
                end else begin
                    rexp_t e;
                    e = q_r.pop_front();
                    chk("rdata", S_AXI_RDATA, e.data);
                    chk("rresp", S_AXI_RRESP, e.resp);
                end
            end
        end
    end

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return (v == 32'd7) ? 32'd5 : v + 32'd1;
    endfunction

    initial begin
        logic [31:0] mv;
        logic [31:0] prev;
        int          ph;
        bit          found;
        bit          seen;

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        model_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", S_AXI_AWREADY, 0);
        chk("rst_wready", S_AXI_WREADY, 0);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_count", cnt_value, 0);
        chk("rst_match", cnt_match, 0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;

        // Random register traffic with the counter idle
        for (int n = 0; n < 40; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = {3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                if (a == 5'h00) d[0] = 1'b0;
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 0);
            end else begin
                logic [31:0] ed;
                logic [1:0]  er;
                model_read(a, ed, er);
                axi_read(a, ed, er, $urandom_range(0, 2));
            end
        end

        wr(5'h00, 32'd1); wr(5'h04, 32'd2); wr(5'h08, 32'd3); wr(5'h0C, 32'd4);
        mread(5'h00); mread(5'h04); mread(5'h08); mread(5'h0C);

        // Free-running compare/reload with PRESC=0
        wr(5'h00, 32'd0); wr(5'h04, 32'd5); wr(5'h08, 32'd7);
        wr(5'h0C, 32'd0); wr(5'h10, 32'd5); wr(5'h14, 32'd1);
        wr(5'h00, 32'd1);
        @(negedge ACLK);
        mv = cnt_value;
        chk("cnt_in_range", (mv >= 32'd5 && mv <= 32'd7) ? 32'd1 : 32'd0, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ACLK);
            chk("cnt_match_p0", cnt_match, (mv == 32'd7) ? 32'd1 : 32'd0);
            if (mv == 32'd7) seen = 1'b1;
            mv = nxt(mv);
            chk("cnt_value_p0", cnt_value, mv);
        end
        chk("match_seen", seen, 1);
        @(posedge ACLK);
        #1;
        axi_read(5'h14, 32'h3, 2'b00, 0);

        // PRESC=3: one step every 4 cycles
        wr(5'h0C, 32'd3);
        @(negedge ACLK);
        prev = cnt_value;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge ACLK);
            if (cnt_value != prev) found = 1'b1;
        end
        chk("presc_change_found", found, 1);
        mv = cnt_value;
        ph = 0;
        for (int i = 0; i < 36; i++) begin
            logic em;
            @(negedge ACLK);
            em = 1'b0;
            ph++;
            if (ph == 4) begin
                ph = 0;
                em = (mv == 32'd7);
                mv = nxt(mv);
            end
            chk("cnt_value_p3", cnt_value, mv);
            chk("cnt_match_p3", cnt_match, em);
        end
        @(posedge ACLK);
        #1;

        // EN low freezes the count; then one-shot run
        wr(5'h00, 32'd0); wr(5'h14, 32'd1); wr(5'h10, 32'd5);
        repeat (10) @(negedge ACLK);
        chk("freeze_count", cnt_value, 32'd5);
        @(posedge ACLK);
        #1;
        axi_read(5'h14, 32'h2, 2'b00, 0);
        wr(5'h00, 32'd3);
        repeat (30) @(negedge ACLK);
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            chk("oneshot_hold", cnt_value, 32'd5);
            chk("oneshot_nomatch", cnt_match, 0);
        end
        @(posedge ACLK);
        #1;
        axi_read(5'h14, 32'h1, 2'b00, 0);
        wr(5'h14, 32'd1);
        axi_read(5'h14, 32'h0, 2'b00, 0);

        // Unmapped addresses
        axi_write(5'h18, $urandom, 4'hF, 0, 0, 0);
        axi_read(5'h1C, 32'h0, 2'b10, 1);
        mread(5'h04); mread(5'h08); mread(5'h0C);

        // Late W, held B, byte strobe
        wr(5'h04, 32'd0);
        axi_write(5'h04, 32'hFFFF_FFFF, 4'h1, 3, 5, 1);
        mread(5'h04);

`ifdef CONT_IP_IRQ_EN
        wr(5'h04, 32'd0); wr(5'h08, 32'd2); wr(5'h0C, 32'd0);
        wr(5'h14, 32'd1); wr(5'h10, 32'd0); wr(5'h00, 32'd7);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge ACLK);
            if (cnt_match) found = 1'b1;
        end
        chk("irq_match_found", found, 1);
        chk("irq_before", irq, 0);
        @(negedge ACLK);
        chk("irq_after", irq, 1);
        @(posedge ACLK);
        #1;
        wr(5'h14, 32'd1);
        @(negedge ACLK);
        chk("irq_cleared", irq, 0);
        @(posedge ACLK);
        #1;
`endif

        // Reset while a read response is pending
        S_AXI_ARADDR  = 5'h04;
        S_AXI_ARVALID = 1'b1;
        wait_hs(3);
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        chk("rvalid_pending", S_AXI_RVALID, 1);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst2_rvalid", S_AXI_RVALID, 0);
        chk("rst2_arready", S_AXI_ARREADY, 0);
        chk("rst2_bvalid", S_AXI_BVALID, 0);
        chk("rst2_count", cnt_value, 0);
        model_reset();
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 6; i++) mread(5'(i * 4));

        repeat (5) @(posedge ACLK);
        chk("b_queue_empty", q_b.size(), 0);
        chk("r_queue_empty", q_r.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
